// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_feeder
// Brief    : Word-to-bit serializer with a one-word hold buffer that feeds a
//            serial sequence detector gap-free.
// Revision : 1.0
// ============================================================================
module serial_bit_feeder #(
  parameter int   WIDTH     = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             w_hold_full_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_xfer;
  logic             w_load;
  logic             w_out_bit;

  // Bit order only changes which end is presented and which way we shift.
  if (MSB_FIRST) begin : g_msb_first
    assign w_out_bit = r_shift[WIDTH-1];
    assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_out_bit = r_shift[0];
    assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
  end

  assign din_ready = !r_hold_full && !reset;
  assign w_xfer    = din_valid && din_ready;
  assign busy      = (r_state == S_SHIFT) || r_hold_full;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    x           = IDLE_BIT;
    x_valid     = 1'b0;
    frame_start = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        x           = w_out_bit;
        x_valid     = 1'b1;
        frame_start = (r_cnt == '0);
        if (r_cnt == C_LAST) begin
          // Only a word already waiting chains on; one arriving now waits.
          if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_shift_nxt = r_hold;
      w_cnt_nxt   = '0;
    end

    // din_ready excludes a full hold, so transfer and drain never collide.
    w_hold_full_nxt = w_xfer ? 1'b1 : (w_load ? 1'b0 : r_hold_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_xfer) begin
        r_hold <= din;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_feeder
// Brief    : Scoreboard bench; two feeders (MSB-first/idle 0, LSB-first/idle 1)
//            share stimulus and a timing model of word slots.
// Revision : 1.0
// ============================================================================
module tb_serial_bit_feeder;

  localparam int W = 4;

  typedef struct {
    int           cyc;
    logic [W-1:0] word;
    int           idx;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b1;
  logic         rdy0, x0, xv0, fs0, busy0;
  logic         rdy1, x1, xv1, fs1, busy1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];
  bit   have = 1'b0;
  int   last_s = 0;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .x(x0), .x_valid(xv0), .frame_start(fs0), .busy(busy0)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .x(x1), .x_valid(xv1), .frame_start(fs1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a bit is due on the cycle its slot was scheduled for, else idle fill.
  task automatic mon_check();
    logic due;
    ent_t e;
    due = (sb.size() != 0) && (sb[0].cyc == cyc);
    chk("x_valid_msb", {31'b0, xv0}, {31'b0, due});
    chk("x_valid_lsb", {31'b0, xv1}, {31'b0, due});
    if (due) begin
      e = sb.pop_front();
      chk("x_msb", {31'b0, x0}, {31'b0, e.word[W-1-e.idx]});
      chk("x_lsb", {31'b0, x1}, {31'b0, e.word[e.idx]});
      chk("frame_start_msb", {31'b0, fs0}, {31'b0, e.idx == 0});
      chk("frame_start_lsb", {31'b0, fs1}, {31'b0, e.idx == 0});
    end else begin
      chk("x_idle_msb", {31'b0, x0}, 32'd0);
      chk("x_idle_lsb", {31'b0, x1}, 32'd1);
      chk("frame_start_idle", {30'b0, fs1, fs0}, 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_check();
    end
  end

  // One clock of stimulus. A word accepted at edge T starts at
  // max(T+1, previous start + W); the hold is occupied from T until that start.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic taken);
    int   e, t, s;
    logic exp_rdy, exp_busy;
    ent_t en;
    @(negedge clk);
    reset = r;
    din_valid = v;
    din = d;
    #1;
    e = cyc;
    taken = 1'b0;
    exp_busy = have && (e < last_s + W);
    exp_rdy  = !r && !(have && (e < last_s));
    chk("busy", {30'b0, busy1, busy0}, {30'b0, exp_busy, exp_busy});
    chk("din_ready", {30'b0, rdy1, rdy0}, {30'b0, exp_rdy, exp_rdy});
    if (r) begin
      while (sb.size() != 0 && sb[sb.size()-1].cyc > e) void'(sb.pop_back());
      have = 1'b0;
    end else if (v && exp_rdy) begin
      t = e + 1;
      s = (have && (last_s + W > t + 1)) ? last_s + W : t + 1;
      for (int i = 0; i < W; i++) begin
        en.cyc = s + i;
        en.word = d;
        en.idx = i;
        sb.push_back(en);
      end
      have = 1'b1;
      last_s = s;
      taken = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    logic tk;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, tk);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    logic tk;
    int   n;
    tk = 1'b0;
    n = 0;
    while (!tk && n < 40) begin
      step(1'b1, w, 1'b0, tk);
      n++;
    end
    if (!tk) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word %0h not accepted within %0d cycles", w, n);
    end
  endtask

  initial begin
    logic         tk;
    logic         pend;
    logic         rr;
    logic [W-1:0] pw;

    // Reset held with valid high: nothing may be accepted.
    step(1'b1, 4'b1011, 1'b1, tk);
    step(1'b1, 4'b0110, 1'b1, tk);
    idle(2);

    send_word(4'b1011);
    idle(7);

    send_word(4'b1011);
    send_word(4'b0110);
    idle(10);

    send_word(4'b1101);
    idle(7);

    send_word(4'b1001);
    send_word(4'b0111);
    send_word(4'b1110);
    idle(16);

    // Reset while bit 2 of the first word shows and a second word is held.
    send_word(4'b1011);
    send_word(4'b0110);
    idle(1);
    step(1'b0, 4'b0000, 1'b1, tk);
    idle(10);

    pend = 1'b0;
    pw = '0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 99) < 2);
      if (!pend && $urandom_range(0, 99) < 60) begin
        pend = 1'b1;
        pw = W'($urandom);
      end
      step(pend, pend ? pw : W'($urandom), rr, tk);
      if (tk || rr) pend = 1'b0;
    end
    idle(3 * W + 4);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d scheduled bits never appeared", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
